// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control-token constants, align FSM encoding and decode helpers
//
// Contents:
//   CTRL_TOKEN_xx   10-bit control tokens, suffix is c1c0 (also used by the encoder)
//   align_state_t   word-alignment FSM states
//   is_ctrl_token   1 when a word is one of the four control tokens
//   ctrl_bits       {c1,c0} carried by a control token (00 for non-tokens)
//   decode_data     8-bit pixel value carried by a data word

package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    localparam logic [3:0] MAX_OFFSET = 4'd9;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        return (w == CTRL_TOKEN_00) || (w == CTRL_TOKEN_01) ||
               (w == CTRL_TOKEN_10) || (w == CTRL_TOKEN_11);
    endfunction

    function automatic logic [1:0] ctrl_bits(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            CTRL_TOKEN_01: c = 2'b01;
            CTRL_TOKEN_10: c = 2'b10;
            CTRL_TOKEN_11: c = 2'b11;
            default:       c = 2'b00;
        endcase
        return c;
    endfunction

    // Bit 9 flags an inverted payload, bit 8 selects XOR (1) or XNOR (0)
    // chaining between neighbouring payload bits.
    function automatic logic [7:0] decode_data(input logic [9:0] w);
        logic [7:0] t;
        logic [7:0] d;
        t    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_word_align.sv
// rtl/tmds_word_align.sv - TMDS 10-bit word boundary search and lock tracking
//
// Ports:
//   clkin        in   pixel clock
//   rstin        in   asynchronous active-high reset
//   din[9:0]     in   raw deserialized word, bit 0 received first
//   word_r[9:0]  out  aligned word, registered
//   locked       out  alignment established (FSM in LOCKED)
//   lock_next    out  FSM will be LOCKED after the coming edge; lets the
//                     output stage register locked data on the same edge
//   slip_offset  out  current bit offset, 0..9

module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 64,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [9:0] din,
    output logic [9:0] word_r,
    output logic       locked,
    output logic       lock_next,
    output logic [3:0] slip_offset
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
    localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

    align_state_t      state;
    align_state_t      state_next;
    logic [9:0]        din_q;
    logic [19:0]       cat;
    logic [9:0]        aligned;
    logic              token;

    logic [RUN_W-1:0]  run_cnt;
    logic [RUN_W-1:0]  run_inc;
    logic [RUN_W-1:0]  run_next;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_inc;
    logic [WIN_W-1:0]  win_next;
    logic [LOSS_W-1:0] loss_cnt;
    logic [LOSS_W-1:0] loss_inc;
    logic [LOSS_W-1:0] loss_next;
    logic [3:0]        offset_next;

    logic              run_full;
    logic              win_full;
    logic              loss_full;

    // The older word sits in the low half, so offset k picks the last
    // 10-k bits of the previous word followed by the first k bits of
    // the current one.
    assign cat     = {din, din_q};
    assign aligned = 10'(cat >> slip_offset);
    assign token   = is_ctrl_token(word_r);

    // Saturating increments; the FSM clears the counters long before they
    // saturate, but a stuck count is safer than a wrapped one.
    assign run_inc  = (run_cnt  == '1) ? run_cnt  : run_cnt  + 1'b1;
    assign win_inc  = (win_cnt  == '1) ? win_cnt  : win_cnt  + 1'b1;
    assign loss_inc = (loss_cnt == '1) ? loss_cnt : loss_cnt + 1'b1;

    assign run_full  = token  && (run_inc  == RUN_W'(LOCK_TOKENS));
    assign win_full  =            (win_inc  == WIN_W'(SEARCH_WINDOW));
    assign loss_full = !token && (loss_inc == LOSS_W'(LOSS_TIMEOUT));

    // State, counters and datapath registers
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state       <= ST_SEARCH;
            din_q       <= '0;
            word_r      <= '0;
            run_cnt     <= '0;
            win_cnt     <= '0;
            loss_cnt    <= '0;
            slip_offset <= '0;
        end else begin
            state       <= state_next;
            din_q       <= din;
            word_r      <= aligned;
            run_cnt     <= run_next;
            win_cnt     <= win_next;
            loss_cnt    <= loss_next;
            slip_offset <= offset_next;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_next  = state;
        run_next    = run_cnt;
        win_next    = win_cnt;
        loss_next   = loss_cnt;
        offset_next = slip_offset;

        case (state)
            ST_SEARCH: begin
                run_next = token ? run_inc : '0;
                win_next = win_inc;
                // A completed run takes priority over an expiring window.
                if (run_full) begin
                    state_next = ST_LOCKED;
                    run_next   = '0;
                    win_next   = '0;
                    loss_next  = '0;
                end else if (win_full) begin
                    state_next = ST_SLIP;
                    run_next   = '0;
                    win_next   = '0;
                end
            end

            ST_SLIP: begin
                // word_r in this cycle was taken at the old offset; it is
                // not counted toward either counter.
                offset_next = (slip_offset == MAX_OFFSET) ? 4'd0 : slip_offset + 4'd1;
                run_next    = '0;
                win_next    = '0;
                state_next  = ST_SEARCH;
            end

            ST_LOCKED: begin
                loss_next = token ? '0 : loss_inc;
                // Keep the offset: a brief outage usually relocks at once.
                if (loss_full) begin
                    state_next = ST_SEARCH;
                    run_next   = '0;
                    win_next   = '0;
                    loss_next  = '0;
                end
            end

            default: begin
                state_next = ST_SEARCH;
                run_next   = '0;
                win_next   = '0;
                loss_next  = '0;
            end
        endcase
    end

    // Status outputs
    always_comb begin
        locked    = (state == ST_LOCKED);
        lock_next = (state_next == ST_LOCKED);
    end

endmodule

// File: rtl/tmds_decode.sv
// rtl/tmds_decode.sv - TMDS receive channel decoder with word alignment
//
// Ports:
//   clkin        in   pixel clock (deserializer parallel clock)
//   rstin        in   asynchronous active-high reset
//   din[9:0]     in   raw deserialized word, bit 0 received first
//   dout[7:0]    out  decoded pixel data, 0 unless de
//   c0, c1       out  control bits; hold the last token value during data
//   de           out  data enable, 1 = dout is valid video
//   locked       out  word alignment established
//   slip_offset  out  current bit offset 0..9 (debug)

module tmds_decode
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 64,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic       clkin,
    input  logic       rstin,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip_offset
);

    logic [9:0] word_r;
    logic       lock_next;

    tmds_word_align #(
        .LOCK_TOKENS   (LOCK_TOKENS),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) u_align (
        .clkin       (clkin),
        .rstin       (rstin),
        .din         (din),
        .word_r      (word_r),
        .locked      (locked),
        .lock_next   (lock_next),
        .slip_offset (slip_offset)
    );

    // Output stage keys off lock_next so the word that completes the lock
    // run is decoded on the same edge that raises locked, and de drops on
    // the same edge that locked falls.
    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            dout <= '0;
            c0   <= 1'b0;
            c1   <= 1'b0;
            de   <= 1'b0;
        end else if (!lock_next) begin
            dout <= '0;
            c0   <= 1'b0;
            c1   <= 1'b0;
            de   <= 1'b0;
        end else if (is_ctrl_token(word_r)) begin
            dout     <= '0;
            de       <= 1'b0;
            {c1, c0} <= ctrl_bits(word_r);
        end else begin
            dout <= decode_data(word_r);
            de   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tmds_decode.sv
// tb/tb_tmds_decode.sv - scoreboard bench for tmds_decode with a serial-stream reference model

module tb_tmds_decode;

    localparam int LOCK_TOKENS   = 64;
    localparam int SEARCH_WINDOW = 2048;
    localparam int LOSS_TIMEOUT  = 4096;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clkin = 1'b0;
    logic       rstin = 1'b0;
    logic [9:0] din   = '0;
    logic [7:0] dout;
    logic       c0, c1, de, locked;
    logic [3:0] slip_offset;

    tmds_decode #(
        .LOCK_TOKENS   (LOCK_TOKENS),
        .SEARCH_WINDOW (SEARCH_WINDOW),
        .LOSS_TIMEOUT  (LOSS_TIMEOUT)
    ) dut (
        .clkin       (clkin),
        .rstin       (rstin),
        .din         (din),
        .dout        (dout),
        .c0          (c0),
        .c1          (c1),
        .de          (de),
        .locked      (locked),
        .slip_offset (slip_offset)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [7:0] dout;
        logic [1:0] c;
        logic       de;
        logic       locked;
        logic [3:0] off;
    } exp_t;

    exp_t sb_q[$];
    bit   bitq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (mode: 0 search, 1 slip, 2 locked)
    logic [9:0] m_prev;
    logic [9:0] m_word;
    int         m_off, m_mode, m_run, m_win, m_loss;
    exp_t       m_exp;

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            T00:     return 0;
            T01:     return 1;
            T10:     return 2;
            T11:     return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [9:0] tok_word(input int code);
        case (code)
            1:       return T01;
            2:       return T10;
            3:       return T11;
            default: return T00;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] t;
        logic [7:0] d;
        t    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) d[i] = (t[i] == t[i-1]) ? ~w[8] : w[8];
        return d;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        while (tok_code(w) >= 0) w = 10'($urandom);
        return w;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_word = '0;
        m_off = 0; m_mode = 0; m_run = 0; m_win = 0; m_loss = 0;
        m_exp = '{dout: 8'h00, c: 2'b00, de: 1'b0, locked: 1'b0, off: 4'd0};
    endtask

    // Advance the model by one clock given the word sampled on that edge.
    task automatic model_step(input logic [9:0] w);
        logic [19:0] pair;
        logic [9:0]  next_word;
        int          tk;
        pair      = {w, m_prev};
        next_word = 10'(pair >> m_off);
        tk        = tok_code(m_word);
        case (m_mode)
            0: begin
                m_win++;
                m_run = (tk >= 0) ? m_run + 1 : 0;
                if (m_run == LOCK_TOKENS) begin
                    m_mode = 2; m_run = 0; m_win = 0; m_loss = 0;
                end else if (m_win == SEARCH_WINDOW) begin
                    m_mode = 1; m_run = 0; m_win = 0;
                end
            end
            1: begin
                m_off = (m_off + 1) % 10; m_mode = 0; m_run = 0; m_win = 0;
            end
            default: begin
                m_loss = (tk >= 0) ? 0 : m_loss + 1;
                if (m_loss == LOSS_TIMEOUT) begin
                    m_mode = 0; m_run = 0; m_win = 0; m_loss = 0;
                end
            end
        endcase
        if (m_mode == 2) begin
            if (tk >= 0) begin
                m_exp.dout = 8'h00; m_exp.de = 1'b0; m_exp.c = 2'(tk);
            end else begin
                m_exp.dout = ref_decode(m_word); m_exp.de = 1'b1;
            end
        end else begin
            m_exp.dout = 8'h00; m_exp.de = 1'b0; m_exp.c = 2'b00;
        end
        m_exp.locked = (m_mode == 2);
        m_exp.off    = 4'(m_off);
        m_word = next_word;
        m_prev = w;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic [9:0] w);
        din = w;
        @(posedge clkin);
        #1;
        model_step(w);
        sb_q.push_back(m_exp);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) bitq.push_back(w[i]);
        while (bitq.size() >= 10) begin
            logic [9:0] x;
            for (int i = 0; i < 10; i++) x[i] = bitq.pop_front();
            drive_cycle(x);
        end
    endtask

    // Delays the serial stream by n bits, moving the correct offset up by n.
    task automatic shift_phase(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        rstin = 1'b1;
        sb_q.delete();
        bitq.delete();
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_c1c0", 32'({c1, c0}), 0);
        check("rst_de", 32'(de), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_offset", 32'(slip_offset), 0);
        @(posedge clkin); #1;
        @(posedge clkin); #1;
        rstin = 1'b0;
        model_reset();
    endtask

    task automatic lock_with_tokens(input string name);
        int n;
        repeat (LOCK_TOKENS) send_word(T00);
        n = 0;
        while (!locked && n < 6) begin
            send_word(rand_data());
            n++;
        end
        check(name, 32'(locked), 1);
    endtask

    // Monitor: compare every registered output against the model.
    always @(negedge clkin) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_tests++;
            if (dout !== e.dout || {c1, c0} !== e.c || de !== e.de ||
                locked !== e.locked || slip_offset !== e.off) begin
                n_fail++;
                $display("FAIL out_cycle@%0t: got dout=%h c1c0=%b de=%b locked=%b off=%0d expected dout=%h c1c0=%b de=%b locked=%b off=%0d",
                         $time, dout, {c1, c0}, de, locked, slip_offset,
                         e.dout, e.c, e.de, e.locked, e.off);
            end
        end
    end

    initial begin
        int  n;
        int  prev_off;
        bit  steps_ok;
        bit  wrap_seen;

        model_reset();
        #1;
        do_reset();

        // 63 tokens then data must not lock
        repeat (LOCK_TOKENS - 1) send_word(T00);
        repeat (8) send_word(rand_data());
        check("no_lock_63", 32'(locked), 0);

        // 64 tokens lock; c1c0 from T00 is held over data
        lock_with_tokens("lock_64");
        check("lock_c1c0_hold", 32'({c1, c0}), 0);

        // Data decode
        repeat (4) send_word(10'b1000000000);
        check("dec_ff_dout", 32'(dout), 32'hFF);
        check("dec_ff_de", 32'(de), 1);
        repeat (4) send_word(10'b0100000000);
        check("dec_00_dout", 32'(dout), 0);
        check("dec_00_de", 32'(de), 1);

        // Remaining control tokens
        for (int k = 1; k < 4; k++) begin
            repeat (4) send_word(tok_word(k));
            check("tok_c1c0", 32'({c1, c0}), 32'(k));
            check("tok_de", 32'(de), 0);
            check("tok_dout", 32'(dout), 0);
        end
        repeat (4) send_word(rand_data());
        check("data_c1c0_hold", 32'({c1, c0}), 3);
        check("data_de", 32'(de), 1);

        // Randomized locked traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) send_word(tok_word(int'($urandom_range(0, 3))));
            else                           send_word(rand_data());
        end
        repeat (3) send_word(rand_data());

        // Reset mid-stream, then relock
        do_reset();
        lock_with_tokens("relock_after_rst");

        // Misaligned by 3 bits
        do_reset();
        shift_phase(3);
        n = 0; prev_off = 0; steps_ok = 1'b1;
        while (!locked && n < 3 * (SEARCH_WINDOW + 1) + LOCK_TOKENS + 8) begin
            send_word(T00);
            n++;
            if (int'(slip_offset) != prev_off) begin
                if (int'(slip_offset) != prev_off + 1) steps_ok = 1'b0;
                prev_off = int'(slip_offset);
            end
        end
        check("mis3_locked", 32'(locked), 1);
        check("mis3_offset", 32'(slip_offset), 3);
        check("mis3_steps", 32'(steps_ok), 1);

        // Loss of tokens drops lock but keeps offset
        repeat (LOSS_TIMEOUT + 4) send_word(rand_data());
        check("loss_locked", 32'(locked), 0);
        check("loss_de", 32'(de), 0);
        check("loss_offset", 32'(slip_offset), 3);

        // Re-search wraps 9 -> 0 and locks at offset 1
        shift_phase(8);
        n = 0; prev_off = int'(slip_offset); wrap_seen = 1'b0;
        while (!locked && n < 9 * (SEARCH_WINDOW + 1) + LOCK_TOKENS + 8) begin
            send_word(T00);
            n++;
            if (prev_off == 9 && slip_offset == 4'd0) wrap_seen = 1'b1;
            prev_off = int'(slip_offset);
        end
        check("wrap_seen", 32'(wrap_seen), 1);
        check("wrap_locked", 32'(locked), 1);
        check("wrap_offset", 32'(slip_offset), 1);

        repeat (4) send_word(rand_data());
        @(negedge clkin);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
